// File: rtl/arbitro_rr5.sv
// Five-way round-robin arbiter with req/done handshake and a per-grant hold limit.
// Optional macro ARB_PRIO0_EN gives requester 0 fixed top priority.
module arbitro_rr5 #(
  parameter int unsigned N_REQ    = 5,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               busy_q;
  logic               timeout_q;
  logic [ID_W-1:0]    ptr_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [N_REQ-1:0]   mask_q;

  logic [N_REQ-1:0]   eligible;
  logic               any_elig;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    ptr_d;
  logic               release_grant;
  logic               hold_hit;

  assign eligible = req & ~mask_q;

  // Winner is the eligible index with the smallest wrapped distance from the pointer.
  always_comb begin
    int unsigned best_d;
    int unsigned d;
    best_d = N_REQ;
    d      = 0;
    win    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (eligible[i]) begin
        d = (i >= 32'(ptr_q)) ? (i - 32'(ptr_q)) : (i + N_REQ - 32'(ptr_q));
        if (d < best_d) begin
          best_d = d;
          win    = ID_W'(i);
        end
      end
    end
    any_elig = (best_d < N_REQ);
    ptr_d    = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
`ifdef ARB_PRIO0_EN
    if (eligible[0]) begin
      win   = '0;
      ptr_d = ptr_q;
    end
`endif
  end

  assign release_grant = (|(done & grant_q)) | ~(|(req & grant_q));
  assign hold_hit      = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_q     <= '0;
      mask_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      mask_q    <= mask_q & req;
      case (state_q)
        StIdle: begin
          if (any_elig) begin
            grant_q    <= N_REQ'(1) << win;
            grant_id_q <= win;
            busy_q     <= 1'b1;
            hold_q     <= '0;
            ptr_q      <= ptr_d;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (release_grant) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else if (hold_hit) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
            // A dropped req in the same cycle still clears the new mask bit.
            mask_q     <= (mask_q | grant_q) & req;
            state_q    <= StIdle;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
